// File: rtl/dm_arbiter_pkg.sv
// Shared widths, instruction field offsets and FSM encoding for the data-memory arbiter.
package dm_arbiter_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int DM_ADDR_WIDTH = 8;
  localparam int INST_WIDTH    = 32;

  localparam int RADDR0_LSB = 0;
  localparam int RADDR1_LSB = 8;
  localparam int WADDR_LSB  = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: writeback, host load, operand fetch and read return.
interface dm_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic          cmp_valid;
  logic          cmp_ready;
  logic [AW-1:0] cmp_raddr0;
  logic [AW-1:0] cmp_raddr1;

  logic          rd_valid;
  logic [DW-1:0] rd_data0;
  logic [DW-1:0] rd_data1;

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  ld_valid, ld_addr, ld_data,
    input  cmp_valid, cmp_raddr0, cmp_raddr1,
    output ld_ready, cmp_ready,
    output rd_valid, rd_data0, rd_data1
  );

  modport master (
    output wb_valid, wb_addr, wb_data,
    output ld_valid, ld_addr, ld_data,
    output cmp_valid, cmp_raddr0, cmp_raddr1,
    input  ld_ready, cmp_ready,
    input  rd_valid, rd_data0, rd_data1
  );

endinterface

// File: rtl/dm_rd_pipe.sv
// Fixed two-stage read-return valid pipeline; with DM_FWD_EN it also carries the
// per-lane collision flags and the colliding write data alongside the valid bit.
module dm_rd_pipe #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rd_issue,
  input  logic [1:0]    i_fwd_hit,
  input  logic [DW-1:0] i_fwd_data,
  output logic          o_rd_valid,
  output logic [1:0]    o_fwd_hit,
  output logic [DW-1:0] o_fwd_data
);

  logic [1:0] r_vld;

  always_ff @(posedge clk) begin
    if (rst) r_vld <= '0;
    else     r_vld <= {r_vld[0], i_rd_issue};
  end

  assign o_rd_valid = r_vld[1];

`ifdef DM_FWD_EN
  logic [1:0]    r_hit_s1, r_hit_s2;
  logic [DW-1:0] r_data_s1, r_data_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_s1  <= '0;
      r_hit_s2  <= '0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      r_hit_s1  <= i_fwd_hit;
      r_hit_s2  <= r_hit_s1;
      r_data_s1 <= i_fwd_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign o_fwd_hit  = r_hit_s2;
  assign o_fwd_data = r_data_s2;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_fwd_hit, i_fwd_data};
  assign o_fwd_hit    = '0;
  assign o_fwd_data   = '0;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Sole driver of one PE's data memory: zero-fill after reset, then merges writeback,
// host load and operand fetch into one issue slot. Optional DM_FWD_EN forwards instead of stalling.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW = DM_ADDR_WIDTH,
  parameter int DW = 2 * DATA_WIDTH,
  parameter int IW = INST_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   req,
  output logic          o_dm_inst_v,
  output logic [IW-1:0] o_dm_inst,
  output logic          o_dm_wren,
  output logic          o_dm_rden,
  output logic [DW-1:0] o_dm_wdata,
  input  logic [DW-1:0] i_dm_rdata0,
  input  logic [DW-1:0] i_dm_rdata1,
  output logic          o_init_done,
  output logic [15:0]   o_stall_cnt
);

  localparam logic [AW-1:0] SWEEP_LAST = '1;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_sweep, w_sweep_nxt;
  logic [DW-1:0] r_wdata;
  logic [15:0]   r_stall;

  logic          w_init, w_run;
  logic          w_wr_wb, w_wr_ld, w_wren, w_rden;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [1:0]    w_hit;
  logic          w_rd_valid;
  logic [1:0]    w_fwd_hit;
  logic [DW-1:0] w_fwd_data;

  // NOTE: registers use <= so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_init      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init      = !rst;
        w_sweep_nxt = r_sweep + AW'(1);
        if (r_sweep == SWEEP_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_run = !rst;
      default: ;
    endcase
  end

  // Write slot: zero-fill in INIT, then writeback has priority over host load.
  assign w_wr_wb = w_run && req.wb_valid;
  assign w_wr_ld = w_run && !req.wb_valid && req.ld_valid;
  assign w_wren  = w_init || w_wr_wb || w_wr_ld;

  always_comb begin
    w_waddr = '0;
    w_wdata = '0;
    if (w_init) begin
      w_waddr = r_sweep;
    end else if (w_wr_wb) begin
      w_waddr = req.wb_addr;
      w_wdata = req.wb_data;
    end else if (w_wr_ld) begin
      w_waddr = req.ld_addr;
      w_wdata = req.ld_data;
    end
  end

  // The memory is read-first, so a read colliding with a same-cycle write would see stale data.
  assign w_hit[0] = w_wren && (req.cmp_raddr0 == w_waddr);
  assign w_hit[1] = w_wren && (req.cmp_raddr1 == w_waddr);

  assign req.ld_ready = w_run && !req.wb_valid;
`ifdef DM_FWD_EN
  assign req.cmp_ready = w_run;
`else
  assign req.cmp_ready = w_run && !(|w_hit);
`endif
  assign w_rden = req.cmp_valid && req.cmp_ready;

  assign o_dm_wren   = w_wren;
  assign o_dm_rden   = w_rden;
  assign o_dm_inst_v = w_wren || w_rden;

  always_comb begin
    o_dm_inst = '0;
    if (w_rden) begin
      o_dm_inst[RADDR0_LSB +: AW] = req.cmp_raddr0;
      o_dm_inst[RADDR1_LSB +: AW] = req.cmp_raddr1;
    end
    if (w_wren) o_dm_inst[WADDR_LSB +: AW] = w_waddr;
  end

  always_ff @(posedge clk) begin
    if (rst) r_wdata <= '0;
    else     r_wdata <= w_wdata;
  end
  assign o_dm_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall <= '0;
    else if (w_run && req.cmp_valid && !req.cmp_ready && (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end
  assign o_stall_cnt = r_stall;
  assign o_init_done = (r_state == ST_RUN);

  dm_rd_pipe #(.DW(DW)) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_rd_issue (w_rden),
    .i_fwd_hit  (w_hit & {2{w_rden}}),
    .i_fwd_data (w_wdata),
    .o_rd_valid (w_rd_valid),
    .o_fwd_hit  (w_fwd_hit),
    .o_fwd_data (w_fwd_data)
  );

  assign req.rd_valid = w_rd_valid;
  assign req.rd_data0 = !w_rd_valid ? '0 : (w_fwd_hit[0] ? w_fwd_data : i_dm_rdata0);
  assign req.rd_data1 = !w_rd_valid ? '0 : (w_fwd_hit[1] ? w_fwd_data : i_dm_rdata1);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a read-first memory model (1-cycle late write data, 2-cycle read).
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        dm_inst_v;
  logic [31:0] dm_inst;
  logic        dm_wren;
  logic        dm_rden;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata0;
  logic [31:0] dm_rdata1;
  logic        init_done;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dm_arbiter_if #(.AW(8), .DW(32)) bus ();

  dm_arbiter #(.AW(8), .DW(32), .IW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (bus),
    .o_dm_inst_v (dm_inst_v),
    .o_dm_inst   (dm_inst),
    .o_dm_wren   (dm_wren),
    .o_dm_rden   (dm_rden),
    .o_dm_wdata  (dm_wdata),
    .i_dm_rdata0 (dm_rdata0),
    .i_dm_rdata1 (dm_rdata1),
    .o_init_done (init_done),
    .o_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write data arrives the cycle after issue; reads see older writes only.
  logic [31:0] mem [256];
  logic        pw_v = 1'b0;
  logic [7:0]  pw_a = '0;
  logic [31:0] s1_0 = '0, s1_1 = '0, n0, n1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
    dm_rdata0 = '0;
    dm_rdata1 = '0;
  end

  always @(posedge clk) begin
    if (pw_v) mem[pw_a] = dm_wdata;
    n0 = dm_rden ? mem[dm_inst[7:0]]  : 32'h0;
    n1 = dm_rden ? mem[dm_inst[15:8]] : 32'h0;
    dm_rdata0 <= s1_0;
    dm_rdata1 <= s1_1;
    s1_0      <= n0;
    s1_1      <= n1;
    pw_v      <= dm_inst_v && dm_wren;
    pw_a      <= dm_inst[23:16];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid   = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ld_valid   = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.cmp_valid  = 1'b0; bus.cmp_raddr0 = '0; bus.cmp_raddr1 = '0;
  endtask

  // Walks the 256 fill cycles; the caller has just released rst.
  task automatic init_sweep();
    for (int i = 0; i < 256; i++) begin
      #2;
      check("init_v",     64'(dm_inst_v), 64'd1);
      check("init_wren",  64'(dm_wren), 64'd1);
      check("init_rden",  64'(dm_rden), 64'd0);
      check("init_waddr", 64'(dm_inst), 64'(i) << 16);
      check("init_done",  64'(init_done), 64'd0);
      check("init_ldrdy", 64'(bus.ld_ready), 64'd0);
      check("init_cmprdy", 64'(bus.cmp_ready), 64'd0);
      check("init_rdv",   64'(bus.rd_valid), 64'd0);
      if (i > 0) check("init_wdata", 64'(dm_wdata), 64'd0);
      tick();
    end
  endtask

  int nz;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();

    // 1. Zero-fill, with requesters pushing throughout to prove they are ignored.
    rst = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 8'hFF; bus.wb_data = 32'h1111_1111;
    bus.ld_valid = 1'b1; bus.ld_addr = 8'hFE; bus.ld_data = 32'h2222_2222;
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'h03; bus.cmp_raddr1 = 8'h04;
    init_sweep();
    idle_inputs();
    #2;
    check("run_done", 64'(init_done), 64'd1);
    check("run_stall0", 64'(stall_cnt), 64'd0);
    check("run_idle_v", 64'(dm_inst_v), 64'd0);
    tick(); tick();
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'h0) nz++;
    check("fill_zero", 64'(nz), 64'd0);

    // 2. Load then dependent fetch on the next cycle.
    bus.ld_valid = 1'b1; bus.ld_addr = 8'd5; bus.ld_data = 32'hA5A5_0001;
    #2;
    check("ld_ready", 64'(bus.ld_ready), 64'd1);
    check("ld_inst",  64'(dm_inst), 64'h0005_0000);
    check("ld_flags", 64'({dm_inst_v, dm_wren, dm_rden}), 64'b110);
    tick();
    bus.ld_valid = 1'b0;
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'd5; bus.cmp_raddr1 = 8'd6;
    #2;
    check("ld_wdata", 64'(dm_wdata), 64'hA5A5_0001);
    check("cmp_ready", 64'(bus.cmp_ready), 64'd1);
    check("cmp_inst", 64'(dm_inst), 64'h0000_0605);
    tick();
    bus.cmp_valid = 1'b0;
    #2;
    check("rd_early", 64'(bus.rd_valid), 64'd0);
    check("wdata_idle", 64'(dm_wdata), 64'd0);
    tick(); #2;
    check("rd_valid", 64'(bus.rd_valid), 64'd1);
    check("rd_data0", 64'(bus.rd_data0), 64'hA5A5_0001);
    check("rd_data1", 64'(bus.rd_data1), 64'd0);

    // Back-to-back fetches give back-to-back returns.
    tick();
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'd5; bus.cmp_raddr1 = 8'd7;
    tick();
    bus.cmp_raddr0 = 8'd6; bus.cmp_raddr1 = 8'd5;
    tick();
    bus.cmp_valid = 1'b0;
    #2;
    check("b2b_v0", 64'(bus.rd_valid), 64'd1);
    check("b2b_d0", 64'({bus.rd_data0, bus.rd_data1}), {32'hA5A5_0001, 32'h0});
    tick(); #2;
    check("b2b_v1", 64'(bus.rd_valid), 64'd1);
    check("b2b_d1", 64'({bus.rd_data0, bus.rd_data1}), {32'h0, 32'hA5A5_0001});
    tick(); #2;
    check("b2b_v2", 64'(bus.rd_valid), 64'd0);

    // 3. Writeback starves load for three cycles; load lands when writeback drops.
    bus.ld_valid = 1'b1; bus.ld_addr = 8'd30; bus.ld_data = 32'hC0DE_0030;
    for (int j = 0; j < 3; j++) begin
      bus.wb_valid = 1'b1; bus.wb_addr = 8'(20 + j); bus.wb_data = 32'hB000_0000 + 32'(j);
      #2;
      check("wb_ldrdy", 64'(bus.ld_ready), 64'd0);
      check("wb_inst",  64'(dm_inst), 64'(20 + j) << 16);
      if (j > 0) check("wb_wdata", 64'(dm_wdata), 64'h0B000_0000 + 64'(j - 1));
      tick();
    end
    bus.wb_valid = 1'b0;
    #2;
    check("ld_late_rdy", 64'(bus.ld_ready), 64'd1);
    check("ld_late_inst", 64'(dm_inst), 64'h001E_0000);
    tick();
    bus.ld_valid = 1'b0;
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'd30; bus.cmp_raddr1 = 8'd22;
    #2;
    check("ld_late_wd", 64'(dm_wdata), 64'hC0DE_0030);
    tick();
    bus.cmp_valid = 1'b0;
    tick(); #2;
    check("wbld_v", 64'(bus.rd_valid), 64'd1);
    check("wbld_d", 64'({bus.rd_data0, bus.rd_data1}), {32'hC0DE_0030, 32'hB000_0002});
    tick();

    // 4. Writeback and fetch collide on address 9.
    bus.wb_valid = 1'b1; bus.wb_addr = 8'd9; bus.wb_data = 32'h1234_5678;
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'd3; bus.cmp_raddr1 = 8'd9;
    #2;
    check("hz_stall0", 64'(stall_cnt), 64'd0);
`ifdef DM_FWD_EN
    check("hz_ready", 64'(bus.cmp_ready), 64'd1);
    check("hz_inst",  64'(dm_inst), 64'h0009_0903);
    tick();
    idle_inputs();
    #2;
    check("hz_stall", 64'(stall_cnt), 64'd0);
    tick(); #2;
`else
    check("hz_ready", 64'(bus.cmp_ready), 64'd0);
    check("hz_inst",  64'(dm_inst), 64'h0009_0000);
    tick();
    bus.wb_valid = 1'b0;
    #2;
    check("hz_ready2", 64'(bus.cmp_ready), 64'd1);
    check("hz_stall",  64'(stall_cnt), 64'd1);
    check("hz_inst2",  64'(dm_inst), 64'h0000_0903);
    tick();
    idle_inputs();
    #2;
    check("hz_rd_early", 64'(bus.rd_valid), 64'd0);
    tick(); #2;
`endif
    check("hz_v", 64'(bus.rd_valid), 64'd1);
    check("hz_d", 64'({bus.rd_data0, bus.rd_data1}), {32'h0, 32'h1234_5678});
    tick();

    // 5. Reset with load and fetch in flight.
    bus.ld_valid = 1'b1; bus.ld_addr = 8'd40; bus.ld_data = 32'h4040_4040;
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'd5; bus.cmp_raddr1 = 8'd9;
    #2;
    check("rs_issue", 64'(dm_inst), 64'h0028_0905);
    tick();
    rst = 1'b1;
    tick(); #2;
    check("rs_inst",  64'({dm_inst_v, dm_inst}), 64'd0);
    check("rs_flags", 64'({dm_wren, dm_rden, init_done}), 64'd0);
    check("rs_wdata", 64'(dm_wdata), 64'd0);
    check("rs_stall", 64'(stall_cnt), 64'd0);
    check("rs_rdy",   64'({bus.ld_ready, bus.cmp_ready}), 64'd0);
    check("rs_rd",    64'({bus.rd_valid, bus.rd_data0, bus.rd_data1}), 64'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    init_sweep();
    #2;
    check("rs_done", 64'(init_done), 64'd1);
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'd40; bus.cmp_raddr1 = 8'd9;
    tick();
    bus.cmp_valid = 1'b0;
    tick(); #2;
    check("rs_refill_v", 64'(bus.rd_valid), 64'd1);
    check("rs_refill_d", 64'({bus.rd_data0, bus.rd_data1}), 64'd0);
    tick();

    // 6. Sustained hazard on address 9.
    bus.wb_valid = 1'b1; bus.wb_addr = 8'd9; bus.wb_data = 32'h9;
    bus.cmp_valid = 1'b1; bus.cmp_raddr0 = 8'd9; bus.cmp_raddr1 = 8'd1;
`ifdef DM_FWD_EN
    repeat (100) tick();
    #2;
    check("sat_ready", 64'(bus.cmp_ready), 64'd1);
    check("sat_cnt",   64'(stall_cnt), 64'd0);
`else
    #2;
    check("sat_ready", 64'(bus.cmp_ready), 64'd0);
    repeat (65534) tick();
    #2;
    check("sat_fffe", 64'(stall_cnt), 64'hFFFE);
    tick(); #2;
    check("sat_ffff", 64'(stall_cnt), 64'hFFFF);
    repeat (4465) tick();
    #2;
    check("sat_hold", 64'(stall_cnt), 64'hFFFF);
`endif
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
